mem8_word_bridge: RTL

MEM8_WORD_BRIDGE -- requirements
Module: mem8_word_bridge

---
 rtl/mem8_word_bridge_if.sv | 12 +
 rtl/mem8_word_bridge.sv | 84 ++++++++
 2 files changed

// File: rtl/mem8_word_bridge_if.sv
// iBus8: byte-wide memory bus between an initiator and a responder
interface iBus8 #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
);
  logic           we;
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] vo;
  modport master (output we, ai, vi, input vo);
  modport slave  (input we, ai, vi, output vo);
endinterface

// File: rtl/mem8_word_bridge.sv
// mem8_word_bridge: splits byte/half/word accesses into sequential iBus8 byte transfers
module mem8_word_bridge #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           rw,
  input  logic [1:0]     sz,
  input  logic [ASZ-1:0] addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic           ack,
  output logic           err,
  output logic           busy,
  iBus8.master           b8
);
  typedef enum logic [1:0] {IDLE, XFER, RTAIL, DONE} state_t;
  state_t         state, state_nxt;
  logic           rw_r, err_r, bad;
  logic [2:0]     n_r, k, n_req;
  logic [ASZ-1:0] addr_r;
  logic [31:0]    wdata_r, keep;
  logic [ASZ:0]   last;
  logic [4:0]     cap_sh;
  assign n_req  = sz == 2'd0 ? 3'd1 : sz == 2'd1 ? 3'd2 : sz == 2'd2 ? 3'd4 : 3'd0;
  assign keep   = sz == 2'd0 ? 32'h0000_00ff : sz == 2'd1 ? 32'h0000_ffff : 32'hffff_ffff;
  assign last   = {1'b0, addr} + (ASZ+1)'(n_req) - (ASZ+1)'(1);
  assign bad    = sz == 2'd3 || last[ASZ];
  assign cap_sh = {k[1:0] - 2'd1, 3'b000};
  assign busy   = state != IDLE;
  assign ack    = state == DONE;
  assign err    = ack && err_r;
  // a write strobe is withheld in a reset cycle so an aborted transfer never writes again
  assign b8.we  = state == XFER && rw_r && !rst;
  assign b8.ai  = state == XFER ? addr_r + ASZ'(k) : '0;
  assign b8.vi  = state == XFER && rw_r ? DSZ'(wdata_r >> {k[1:0], 3'b000}) : '0;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // next-state logic; out-of-range or illegal requests skip straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req ? (bad ? DONE : XFER) : IDLE;
      XFER:    state_nxt = k == n_r - 3'd1 ? (rw_r ? DONE : RTAIL) : XFER;
      RTAIL:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // request latch, byte index and read-data capture (vo lags ai by one clock)
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_r    <= 1'b0;
      err_r   <= 1'b0;
      n_r     <= '0;
      k       <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          rw_r    <= rw;
          err_r   <= bad;
          n_r     <= n_req;
          k       <= '0;
          addr_r  <= addr;
          wdata_r <= wdata;
          if (!rw && !bad) rdata <= rdata & keep;
        end
        XFER: begin
          k <= k + 3'd1;
          if (!rw_r && k != 3'd0) rdata[cap_sh +: 8] <= b8.vo[7:0];
        end
        RTAIL:   rdata[cap_sh +: 8] <= b8.vo[7:0];
        default: ;
      endcase
    end
  end
endmodule
